// File: rtl/conv_pipe.sv
// WebAssembly integer/float conversion unit: decodes a conversion opcode and
// carries the converted bits through a stall-all pipeline of STAGES registers.
module conv_pipe #(
  parameter int         STAGES      = 2,
  parameter int         USE_64B     = 1,
  parameter logic [3:0] TRAP_OPCODE = 4'd1,
  parameter logic [3:0] TRAP_NO64   = 4'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  opcode,
  input  logic [63:0] operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic [1:0]  result_type,
  output logic [3:0]  trap
);

  typedef enum logic [1:0] {
    TYPE_I32 = 2'd0,
    TYPE_I64 = 2'd1,
    TYPE_F32 = 2'd2,
    TYPE_F64 = 2'd3
  } res_type_e;

  typedef struct packed {
    logic [63:0] result;
    logic [1:0]  rtype;
    logic [3:0]  trap;
  } entry_t;

  entry_t              conv_entry;
  logic                needs_64b;
  entry_t              stage_q [STAGES];
  logic [STAGES-1:0]   stage_valid;
  logic                advance;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    conv_entry = '0;
    needs_64b  = 1'b0;
    unique case (opcode)
      8'hA7: begin
        conv_entry.result = {32'h0, operand[31:0]};
        conv_entry.rtype  = TYPE_I32;
        needs_64b         = 1'b1;
      end
      8'hAC: begin
        conv_entry.result = {{32{operand[31]}}, operand[31:0]};
        conv_entry.rtype  = TYPE_I64;
        needs_64b         = 1'b1;
      end
      8'hAD: begin
        conv_entry.result = {32'h0, operand[31:0]};
        conv_entry.rtype  = TYPE_I64;
        needs_64b         = 1'b1;
      end
      8'hBC: begin
        conv_entry.result = {32'h0, operand[31:0]};
        conv_entry.rtype  = TYPE_I32;
      end
      8'hBD: begin
        conv_entry.result = operand;
        conv_entry.rtype  = TYPE_I64;
        needs_64b         = 1'b1;
      end
      8'hBE: begin
        conv_entry.result = {32'h0, operand[31:0]};
        conv_entry.rtype  = TYPE_F32;
      end
      8'hBF: begin
        conv_entry.result = operand;
        conv_entry.rtype  = TYPE_F64;
        needs_64b         = 1'b1;
      end
      8'hC0: begin
        conv_entry.result = {32'h0, {24{operand[7]}}, operand[7:0]};
        conv_entry.rtype  = TYPE_I32;
      end
      8'hC1: begin
        conv_entry.result = {32'h0, {16{operand[15]}}, operand[15:0]};
        conv_entry.rtype  = TYPE_I32;
      end
      8'hC2: begin
        conv_entry.result = {{56{operand[7]}}, operand[7:0]};
        conv_entry.rtype  = TYPE_I64;
        needs_64b         = 1'b1;
      end
      8'hC3: begin
        conv_entry.result = {{48{operand[15]}}, operand[15:0]};
        conv_entry.rtype  = TYPE_I64;
        needs_64b         = 1'b1;
      end
      8'hC4: begin
        conv_entry.result = {{32{operand[31]}}, operand[31:0]};
        conv_entry.rtype  = TYPE_I64;
        needs_64b         = 1'b1;
      end
      default: begin
        conv_entry.trap = TRAP_OPCODE;
      end
    endcase

    // A 64-bit build option that is off turns the op into a trapping i32 zero.
    if (needs_64b && (USE_64B == 0)) begin
      conv_entry.result = '0;
      conv_entry.rtype  = TYPE_I32;
      conv_entry.trap   = TRAP_NO64;
    end
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance || flush;

  // NOTE: stage payloads are reset as well as valids, so outputs are never X after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      if (advance) begin
        stage_valid[0] <= in_valid;
        stage_q[0]     <= conv_entry;
        for (int i = 1; i < STAGES; i++) begin
          stage_valid[i] <= stage_valid[i-1];
          stage_q[i]     <= stage_q[i-1];
        end
      end
      // Flush wins over the shift: the op offered this cycle is dropped too.
      if (flush) stage_valid <= '0;
    end
  end

  assign out_valid   = stage_valid[STAGES-1];
  assign result      = stage_q[STAGES-1].result;
  assign result_type = stage_q[STAGES-1].rtype;
  assign trap        = stage_q[STAGES-1].trap;

endmodule

// File: tb/tb_conv_pipe.sv
// Scoreboard bench for conv_pipe: one 64-bit build (STAGES=2) and one build
// without 64-bit ops (STAGES=3) share the stimulus and are checked separately.
module tb_conv_pipe;

  localparam int ST_A = 2;
  localparam int ST_B = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  opcode = '0;
  logic [63:0] operand = '0;
  logic        out_ready = 1'b1;
  logic        out_ready_b = 1'b1;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [63:0] result_a, result_b;
  logic [1:0]  type_a, type_b;
  logic [3:0]  trap_a, trap_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls_a = 0;

  typedef struct {
    logic [63:0] res;
    logic [1:0]  typ;
    logic [3:0]  trp;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  conv_pipe #(.STAGES(ST_A), .USE_64B(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .opcode(opcode), .operand(operand),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .result_type(type_a), .trap(trap_a)
  );

  conv_pipe #(.STAGES(ST_B), .USE_64B(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .opcode(opcode), .operand(operand),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .result(result_b), .result_type(type_b), .trap(trap_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each opcode is a source width, signedness and destination type.
  function automatic exp_t model(input logic [7:0] op, input logic [63:0] v, input bit use64);
    exp_t        e;
    int          w = 32;
    bit          sgn = 1'b0;
    bit          legal = 1'b1;
    logic [1:0]  dt = 2'd0;
    logic [63:0] mask, r;
    case (op)
      8'hA7: begin w = 32; dt = 2'd0; end
      8'hAC: begin w = 32; sgn = 1; dt = 2'd1; end
      8'hAD: begin w = 32; dt = 2'd1; end
      8'hBC: begin w = 32; dt = 2'd0; end
      8'hBD: begin w = 64; dt = 2'd1; end
      8'hBE: begin w = 32; dt = 2'd2; end
      8'hBF: begin w = 64; dt = 2'd3; end
      8'hC0: begin w = 8;  sgn = 1; dt = 2'd0; end
      8'hC1: begin w = 16; sgn = 1; dt = 2'd0; end
      8'hC2: begin w = 8;  sgn = 1; dt = 2'd1; end
      8'hC3: begin w = 16; sgn = 1; dt = 2'd1; end
      8'hC4: begin w = 32; sgn = 1; dt = 2'd1; end
      default: legal = 1'b0;
    endcase
    e.res = '0; e.typ = 2'd0; e.trp = 4'd0; e.cyc = 0; e.stl = 0;
    if (!legal) e.trp = 4'd1;
    else if (!use64 && (op == 8'hA7 || dt[0])) e.trp = 4'd2;
    else begin
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      r = v & mask;
      if (sgn && v[w-1]) r = r | ~mask;
      if (!dt[0]) r = r & 64'hFFFF_FFFF;
      e.res = r;
      e.typ = dt;
    end
    return e;
  endfunction

  function automatic logic [7:0] rand_op();
    logic [7:0] ops [13] = '{8'hA7, 8'hAC, 8'hAD, 8'hBC, 8'hBD, 8'hBE, 8'hBF,
                             8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h6A};
    int k = $urandom_range(0, 15);
    if (k < 13) return ops[k];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic step(input bit iv, input logic [7:0] op, input logic [63:0] opd,
                      input bit ordy, input bit fl, input bit rst);
    @(posedge clk);
    #1;
    in_valid = iv; opcode = op; operand = opd;
    out_ready = ordy; flush = fl; reset = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Expected responses are queued at each accepted transfer.
  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (in_valid && in_ready_a) begin
        e = model(opcode, operand, 1'b1);
        e.cyc = cyc; e.stl = stalls_a;
        q_a.push_back(e);
      end
      if (in_valid && in_ready_b) begin
        e = model(opcode, operand, 1'b0);
        e.cyc = cyc; e.stl = stalls_a;
        q_b.push_back(e);
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic [63:0] prev_res;
  logic [1:0]  prev_typ;
  logic [3:0]  prev_trp;

  always @(posedge clk) begin
    cyc++;
    if (prev_stall) stalls_a++;
  end

  // Monitor for the 64-bit build: data, latency, stall hold and handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("no_x_a", 64'($isunknown({out_valid_a, in_ready_a, result_a, type_a, trap_a})), 64'd0);
      check("in_ready_a", in_ready_a, !out_valid_a || out_ready || flush);
      if (prev_stall) begin
        check("hold_valid_a", out_valid_a, 1'b1);
        check("hold_result_a", result_a, prev_res);
        check("hold_type_a", type_a, prev_typ);
        check("hold_trap_a", trap_a, prev_trp);
      end
      if (!flush && out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_out_a: got result %h with nothing expected", result_a);
        end else begin
          e = q_a.pop_front();
          check("result_a", result_a, e.res);
          check("type_a", type_a, e.typ);
          check("trap_a", trap_a, e.trp);
          check("latency_a", cyc - e.cyc, ST_A + (stalls_a - e.stl));
        end
      end
    end
    prev_stall = !reset && !flush && out_valid_a && !out_ready;
    prev_res = result_a; prev_typ = type_a; prev_trp = trap_a;
  end

  // Monitor for the 32-bit-only build, which is never back-pressured.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("in_ready_b", in_ready_b, 1'b1);
      if (!flush && out_valid_b) begin
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_out_b: got result %h with nothing expected", result_b);
        end else begin
          e = q_b.pop_front();
          check("result_b", result_b, e.res);
          check("type_b", type_b, e.typ);
          check("trap_b", trap_b, e.trp);
          check("latency_b", cyc - e.cyc, ST_B);
        end
      end
    end
  end

  logic        cap_v [8];
  logic [63:0] cap_res [8];
  logic [1:0]  cap_typ [8];
  logic [3:0]  cap_trp [8];

  initial begin
    logic [7:0]  t_op  [3];
    logic [63:0] t_opd [3];
    int r;

    repeat (3) @(posedge clk);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_out_valid_a", out_valid_a, 1'b0);
    check("rst_result_a", result_a, 64'h0);
    check("rst_type_a", type_a, 2'd0);
    check("rst_trap_a", trap_a, 4'd0);
    check("rst_in_ready_a", in_ready_a, 1'b1);
    check("rst_out_valid_b", out_valid_b, 1'b0);

    // Single f32.reinterpret_i32 shows up exactly two cycles after acceptance.
    step(1'b1, 8'hBE, 64'h0000_0000_C000_0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_early_valid", out_valid_a, 1'b0);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_valid", out_valid_a, 1'b1);
    check("lat_result", result_a, 64'h0000_0000_C000_0000);
    check("lat_type", type_a, 2'd2);
    check("lat_trap", trap_a, 4'd0);
    idle(3);

    // Back-to-back extends leave on consecutive cycles.
    t_op  = '{8'hAC, 8'hAD, 8'hC0};
    t_opd = '{64'h8000_0000, 64'h8000_0000, 64'hFF};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1'b1, t_op[i], t_opd[i], 1'b1, 1'b0, 1'b0);
      else       step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      cap_v[i] = out_valid_a; cap_res[i] = result_a; cap_typ[i] = type_a;
    end
    check("b2b_gap0", cap_v[1], 1'b0);
    check("b2b_v0", cap_v[2], 1'b1);
    check("b2b_v1", cap_v[3], 1'b1);
    check("b2b_v2", cap_v[4], 1'b1);
    check("b2b_after", cap_v[5], 1'b0);
    check("b2b_res0", cap_res[2], 64'hFFFF_FFFF_8000_0000);
    check("b2b_res1", cap_res[3], 64'h0000_0000_8000_0000);
    check("b2b_res2", cap_res[4], 64'h0000_0000_FFFF_FFFF);
    check("b2b_typ0", cap_typ[2], 2'd1);
    check("b2b_typ2", cap_typ[4], 2'd0);
    idle(4);

    // Fill the pipe, hold back-pressure for three cycles while still offering.
    step(1'b1, 8'hC4, 64'h0000_0000_8000_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC1, 64'h0000_0000_0000_8001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hC2, 64'h55, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_in_ready", in_ready_a, 1'b0);
      check("stall_out_valid", out_valid_a, 1'b1);
    end
    idle(5);

    // 64-bit build option off: trap codes, then a normal op.
    t_op  = '{8'hBF, 8'h6A, 8'hBC};
    t_opd = '{64'hDEAD_BEEF_0123_4567, 64'h1, 64'h1234_5678_3F80_0000};
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1'b1, t_op[i], t_opd[i], 1'b1, 1'b0, 1'b0);
      else       step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      cap_v[i] = out_valid_b; cap_res[i] = result_b; cap_trp[i] = trap_b;
    end
    check("no64_v0", cap_v[3], 1'b1);
    check("no64_trap_bf", cap_trp[3], 4'd2);
    check("no64_res_bf", cap_res[3], 64'h0);
    check("no64_trap_6a", cap_trp[4], 4'd1);
    check("no64_trap_bc", cap_trp[5], 4'd0);
    check("no64_res_bc", cap_res[5], 64'h0000_0000_3F80_0000);
    idle(3);

    // Flush with two ops in flight (oldest one also being consumed).
    step(1'b1, 8'hC4, 64'h7777_0000_8000_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hAD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hBE, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_in_ready", in_ready_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("flush_out_valid_a", out_valid_a, 1'b0);
      check("flush_out_valid_b", out_valid_b, 1'b0);
    end
    step(1'b1, 8'hC2, 64'h80, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Reset with the pipe full.
    step(1'b1, 8'hAC, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBD, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 64'h8000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid_a, 1'b0);
    check("mid_rst_result", result_a, 64'h0);
    check("mid_rst_type", type_a, 2'd0);
    check("mid_rst_trap", trap_a, 4'd0);
    check("mid_rst_in_ready", in_ready_a, 1'b1);
    idle(5);

    // Random traffic with random back-pressure, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      step($urandom_range(0, 99) < 70, rand_op(), {$urandom, $urandom},
           $urandom_range(0, 99) < 70, r < 5, r == 199);
    end
    idle(10);
    @(negedge clk);
    check("drain_q_a", q_a.size(), 0);
    check("drain_q_b", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_pipe.md
CONV_PIPE -- requirements
Module: conv_pipe

Interface
REQ-001 Parameter STAGES, default 2, pipeline depth (legal 1..4).
REQ-002 Parameter USE_64B, default 1; 0 = 64-bit opcodes unsupported.
REQ-003 Parameter TRAP_OPCODE, default 4'd1, trap code for non-conversion opcode.
REQ-004 Parameter TRAP_NO64, default 4'd2, trap code for 64-bit opcode when USE_64B=0.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 flush  input  1  synchronous discard of all in-flight entries.
REQ-008 in_valid  input  1  upstream offers an operation.
REQ-009 in_ready  output  1  block accepts the operation this cycle.
REQ-010 opcode  input  8  WebAssembly conversion opcode.
REQ-011 operand  input  64  source value; upper 32 bits ignored for 32-bit sources.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 result  output  64  converted bits; upper 32 zero for i32/f32 results.
REQ-015 result_type  output  2  i32=0, i64=1, f32=2, f64=3.
REQ-016 trap  output  4  0 = no trap, else trap code; qualified by out_valid.

Function
REQ-017 Supported opcodes: A7 i32.wrap_i64, AC i64.extend_i32_s, AD i64.extend_i32_u, BC i32.reinterpret_f32, BD i64.reinterpret_f64, BE f32.reinterpret_i32, BF f64.reinterpret_i64, C0 i32.extend8_s, C1 i32.extend16_s, C2 i64.extend8_s, C3 i64.extend16_s, C4 i64.extend32_s.
REQ-018 Reinterpret ops: result bits equal source bits (32 or 64), type set to destination type.
REQ-019 wrap: result = {32'h0, operand[31:0]}, type i32.
REQ-020 extend_s: sign-extend low 8/16/32 bits to destination width; extend_u: zero-extend low 32 bits.
REQ-021 64-bit opcodes (A7, AC, AD, BD, BF, C2-C4) with USE_64B=0: result 0, type i32, trap TRAP_NO64.
REQ-022 Any other opcode: result 0, type i32, trap TRAP_OPCODE; pipeline keeps running.
REQ-023 Stall-all pipeline of STAGES registered stages; advance = !out_valid || out_ready.
REQ-024 in_ready = advance; transfer occurs when in_valid && in_ready.
REQ-025 Latency: accepted op appears at out_valid exactly STAGES cycles later when no stall.
REQ-026 Throughput one op per cycle with out_ready held high; no bubbles inserted.
REQ-027 While out_valid && !out_ready: all stages, result, result_type, trap hold stable.
REQ-028 Bubbles (in_valid low) propagate as invalid stages; they never assert out_valid.
REQ-029 Ops leave in acceptance order; no op lost or duplicated under any stall pattern.
REQ-030 flush: all stage valids cleared next cycle; in_ready high in flush cycle, but op offered that cycle is discarded.
REQ-031 flush and out_ready same cycle: output entry dropped, counted as not consumed.
REQ-032 Data/type/trap of invalid stages are don't-care but shall not produce X on outputs after reset.

Reset
REQ-033 reset has priority over flush and all handshakes.
REQ-034 Reset values: out_valid 0, result 0, result_type 0, trap 0, all stage valids 0.
REQ-035 in_ready is 1 in the first cycle after reset deasserts.
REQ-036 Reset mid-operation discards all in-flight ops; none emerge afterwards.

Verification
REQ-037 STAGES=2: op BE, operand 64'h00000000_C0000000, out_ready=1 -> two cycles later out_valid=1, result 32'hC0000000, type f32, trap 0.
REQ-038 Back-to-back AC 64'h80000000 then AD 64'h80000000 then C0 64'hFF -> results 64'hFFFFFFFF80000000 (i64), 64'h0000000080000000 (i64), 32'hFFFFFFFF (i32), consecutive cycles.
REQ-039 Stall: out_ready low 3 cycles with pipeline full -> in_ready low, output held stable, then drains in order with no loss.
REQ-040 USE_64B=0: opcode BF -> trap 2, result 0; opcode 6A (i32.add) -> trap 1; following BC op completes normally.
REQ-041 flush with 2 ops in flight -> out_valid 0 next cycle, neither op emerges; new op after flush emerges at normal latency.
REQ-042 Reset asserted with pipeline full -> next cycle out_valid 0, all outputs 0, in_ready 1 after release.
